// File: rtl/sdram_clk_mon_pkg.sv
// Shared types and default constants for the SDRAM clock monitor.
// Defaults are derived from the team clocks: sys_clk 10 ns, sdram_clk 20 ns.
package sdram_clk_mon_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StMeasure,
    StReport
  } state_e;

  localparam int unsigned SysClkPeriodNs   = 10;
  localparam int unsigned SdramClkPeriodNs = 20;

  localparam int unsigned DefWinCycles  = 1000;
  // Rising edges of sdram_clk expected in one window of sys_clk cycles.
  localparam int unsigned DefExpEdges   = DefWinCycles * SysClkPeriodNs / SdramClkPeriodNs;
  localparam int unsigned DefTol        = 2;
  localparam int unsigned DefLossCycles = 16;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-stage synchronizer followed by a rising-edge detector.
// Ports:
//   clk_i   sampling clock
//   rst_i   asynchronous active-high reset, clears all flops
//   d_i     asynchronous input (treated as data)
//   rise_o  high for one clk_i cycle per rising edge of the synchronized input
// SyncStages must be at least 2.
module sync_edge_det #(
  parameter int unsigned SyncStages = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic rise_o
);

  logic [SyncStages-1:0] sync_q, sync_d;
  logic                  dly_q, dly_d;

  always_comb begin
    sync_d = {sync_q[SyncStages-2:0], d_i};
    dly_d  = sync_q[SyncStages-1];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      dly_q  <= dly_d;
    end
  end

  assign rise_o = sync_q[SyncStages-1] & ~dly_q;

endmodule

// File: rtl/sdram_clk_mon.sv
// SDRAM clock frequency/presence monitor, entirely in the sys_clk domain.
// Counts synchronized sdram_clk rising edges over WIN_CYCLES sys_clk cycles and
// reports the count plus a pass/fail verdict against EXP_EDGES +/- TOL.
// Ports:
//   sys_clk      only clock, rising edge
//   RESET        asynchronous active-high reset
//   sdram_clk    monitored clock, sampled as data
//   enable       run measurement while high; low aborts the current window
//   edge_count   edge count of the last completed window
//   count_valid  one-cycle pulse when edge_count/freq_ok update
//   freq_ok      last completed window was within tolerance
//   freq_err     sticky failure flag, cleared only by RESET
//   clk_lost     no edge for LOSS_CYCLES cycles
// Optional feature: define CLK_LOSS_DET_EN to build the loss counter;
// otherwise clk_lost is tied low.
module sdram_clk_mon
  import sdram_clk_mon_pkg::*;
#(
  parameter int unsigned WIN_CYCLES  = DefWinCycles,
  parameter int unsigned EXP_EDGES   = DefExpEdges,
  parameter int unsigned TOL         = DefTol,
  parameter int unsigned LOSS_CYCLES = DefLossCycles,
  localparam int unsigned CW         = $clog2(WIN_CYCLES + 1)
) (
  input  logic          sys_clk,
  input  logic          RESET,
  input  logic          sdram_clk,
  input  logic          enable,
  output logic [CW-1:0] edge_count,
  output logic          count_valid,
  output logic          freq_ok,
  output logic          freq_err,
  output logic          clk_lost
);

  if (WIN_CYCLES < 4 || LOSS_CYCLES == 0) begin : g_bad_params
    $error("sdram_clk_mon: WIN_CYCLES must be >= 4 and LOSS_CYCLES > 0");
  end

  localparam logic [CW-1:0] WinLast = CW'(WIN_CYCLES - 1);
  localparam logic [CW-1:0] ExpW    = CW'(EXP_EDGES);
  localparam logic [CW-1:0] CntMax  = '1;

  logic sdram_rise;

  sync_edge_det #(
    .SyncStages(2)
  ) u_sync_edge_det (
    .clk_i (sys_clk),
    .rst_i (RESET),
    .d_i   (sdram_clk),
    .rise_o(sdram_rise)
  );

  state_e        state_q, state_d;
  logic [CW-1:0] win_cnt_q, win_cnt_d;
  logic [CW-1:0] edge_cnt_q, edge_cnt_d;
  logic [CW-1:0] edge_count_q, edge_count_d;
  logic          count_valid_q, count_valid_d;
  logic          freq_ok_q, freq_ok_d;
  logic          freq_err_q, freq_err_d;

  logic [CW-1:0] edge_cnt_inc;
  logic [CW-1:0] dev;
  logic          win_ok;

  // Count including an edge seen this cycle, so the final MEASURE cycle counts.
  always_comb begin
    edge_cnt_inc = (edge_cnt_q == CntMax) ? edge_cnt_q : edge_cnt_q + CW'(sdram_rise);
    // Smaller operand subtracted from the larger: never wraps.
    dev    = (edge_cnt_inc >= ExpW) ? edge_cnt_inc - ExpW : ExpW - edge_cnt_inc;
    win_ok = (32'(dev) <= TOL);
  end

  always_comb begin
    state_d       = state_q;
    win_cnt_d     = win_cnt_q;
    edge_cnt_d    = edge_cnt_q;
    edge_count_d  = edge_count_q;
    count_valid_d = 1'b0;
    freq_ok_d     = freq_ok_q;
    freq_err_d    = freq_err_q;

    unique case (state_q)
      StIdle: begin
        if (enable) begin
          state_d    = StMeasure;
          win_cnt_d  = '0;
          edge_cnt_d = '0;
        end
      end
      StMeasure: begin
        if (!enable) begin
          state_d = StIdle;
        end else begin
          win_cnt_d  = win_cnt_q + 1'b1;
          edge_cnt_d = edge_cnt_inc;
          if (win_cnt_q == WinLast) begin
            // Results register on entry to REPORT so they are visible during it.
            state_d       = StReport;
            edge_count_d  = edge_cnt_inc;
            count_valid_d = 1'b1;
            freq_ok_d     = win_ok;
            if (!win_ok) freq_err_d = 1'b1;
          end
        end
      end
      StReport: begin
        win_cnt_d  = '0;
        edge_cnt_d = '0;
        state_d    = enable ? StMeasure : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk or posedge RESET) begin
    if (RESET) begin
      state_q       <= StIdle;
      win_cnt_q     <= '0;
      edge_cnt_q    <= '0;
      edge_count_q  <= '0;
      count_valid_q <= 1'b0;
      freq_ok_q     <= 1'b0;
      freq_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      win_cnt_q     <= win_cnt_d;
      edge_cnt_q    <= edge_cnt_d;
      edge_count_q  <= edge_count_d;
      count_valid_q <= count_valid_d;
      freq_ok_q     <= freq_ok_d;
      freq_err_q    <= freq_err_d;
    end
  end

  assign edge_count  = edge_count_q;
  assign count_valid = count_valid_q;
  assign freq_ok     = freq_ok_q;
  assign freq_err    = freq_err_q;

`ifdef CLK_LOSS_DET_EN
  localparam int unsigned LW = $clog2(LOSS_CYCLES + 1);
  localparam logic [LW-1:0] LossMax = LW'(LOSS_CYCLES);

  logic [LW-1:0] loss_cnt_q, loss_cnt_d;

  // Runs in every state, independent of the measurement FSM.
  always_comb begin
    loss_cnt_d = loss_cnt_q;
    if (sdram_rise) begin
      loss_cnt_d = '0;
    end else if (loss_cnt_q != LossMax) begin
      loss_cnt_d = loss_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge sys_clk or posedge RESET) begin
    if (RESET) begin
      loss_cnt_q <= '0;
    end else begin
      loss_cnt_q <= loss_cnt_d;
    end
  end

  assign clk_lost = (loss_cnt_q == LossMax);
`else
  assign clk_lost = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_clk_mon.sv
// Directed bench for sdram_clk_mon with a window-result scoreboard.
module tb_sdram_clk_mon;
  import sdram_clk_mon_pkg::*;

  localparam int unsigned WIN = DefWinCycles;
  localparam int unsigned CW  = $clog2(WIN + 1);

  logic          sys_clk;
  logic          RESET;
  logic          sdram_clk;
  logic          enable;
  logic [CW-1:0] edge_count;
  logic          count_valid;
  logic          freq_ok;
  logic          freq_err;
  logic          clk_lost;

  int sdram_half;
  bit sdram_run;
  int n_asserts;
  int n_fail;

  typedef struct {
    string tag;
    int    lo;
    int    hi;
    logic  ok;
    logic  err;
  } exp_t;

  exp_t sb[$];
  exp_t last_exp;

  sdram_clk_mon #(
    .WIN_CYCLES (DefWinCycles),
    .EXP_EDGES  (DefExpEdges),
    .TOL        (DefTol),
    .LOSS_CYCLES(DefLossCycles)
  ) dut (
    .sys_clk    (sys_clk),
    .RESET      (RESET),
    .sdram_clk  (sdram_clk),
    .enable     (enable),
    .edge_count (edge_count),
    .count_valid(count_valid),
    .freq_ok    (freq_ok),
    .freq_err   (freq_err),
    .clk_lost   (clk_lost)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  // sdram_clk source; stopping finishes the current period and holds low.
  initial begin
    sdram_clk = 1'b0;
    forever begin
      if (sdram_run) begin
        sdram_clk = 1'b1;
        #(sdram_half);
        sdram_clk = 1'b0;
        #(sdram_half);
      end else begin
        sdram_clk = 1'b0;
        wait (sdram_run);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input int lo, input int hi, input logic ok,
                          input logic err);
    exp_t e;
    e.tag = tag;
    e.lo  = lo;
    e.hi  = hi;
    e.ok  = ok;
    e.err = err;
    sb.push_back(e);
  endtask

  task automatic check_count(input string tag, input exp_t e);
    logic in_range;
    in_range = (edge_count >= e.lo) && (edge_count <= e.hi);
    n_asserts++;
    assert (in_range === 1'b1)
    else begin
      n_fail++;
      $error("FAIL %s_count: observed %0d expected %0d..%0d", tag, edge_count, e.lo, e.hi);
    end
  endtask

  // Waits for count_valid (bounded), then pops and checks the scoreboard entry.
  task automatic wait_report(output int lat);
    bit   found;
    exp_t e;
    found = 1'b0;
    lat   = 0;
    while (!found && lat < 2 * WIN + 10) begin
      @(posedge sys_clk);
      #1;
      lat++;
      found = (count_valid === 1'b1);
    end
    check("report_timeout", 32'(found), 32'd1);
    if (found) begin
      check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e        = sb.pop_front();
        last_exp = e;
        check_count(e.tag, e);
        check({e.tag, "_freq_ok"}, 32'(freq_ok), 32'(e.ok));
        check({e.tag, "_freq_err"}, 32'(freq_err), 32'(e.err));
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_edge_count"}, 32'(edge_count), 32'd0);
    check({tag, "_count_valid"}, 32'(count_valid), 32'd0);
    check({tag, "_freq_ok"}, 32'(freq_ok), 32'd0);
    check({tag, "_freq_err"}, 32'(freq_err), 32'd0);
    check({tag, "_clk_lost"}, 32'(clk_lost), 32'd0);
  endtask

  initial begin
    int lat;
    int pulses;
    bit seen;

    n_asserts  = 0;
    n_fail     = 0;
    sdram_half = 10;
    sdram_run  = 1'b0;
    RESET      = 1'b1;
    enable     = 1'b0;

    // sdram edges land at 2 mod 10, clear of sys_clk rising edges at 5 mod 10.
    #2 sdram_run = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    check_all_zero("reset");

    @(negedge sys_clk);
    RESET = 1'b0;

    // Nominal windows: first report latency and back-to-back spacing.
    @(negedge sys_clk);
    enable = 1'b1;
    push_exp("w1_nom", 499, 501, 1'b1, 1'b0);
    wait_report(lat);
    check("w1_latency", 32'(lat), 32'(WIN + 1));
    push_exp("w2_nom", 499, 501, 1'b1, 1'b0);
    wait_report(lat);
    check("w2_spacing", 32'(lat), 32'(WIN + 1));

    // Slow sdram_clk (22 ns) fails; freq_err stays set after recovery.
    sdram_half = 11;
    push_exp("w3_slow_edge", 452, 458, 1'b0, 1'b1);
    wait_report(lat);
    push_exp("w4_slow", 453, 456, 1'b0, 1'b1);
    wait_report(lat);
    sdram_half = 10;
    push_exp("w5_recover_edge", 498, 502, 1'b1, 1'b1);
    wait_report(lat);
    push_exp("w6_recover", 499, 501, 1'b1, 1'b1);
    wait_report(lat);

    @(posedge sys_clk);
    #1;
    check("cv_one_cycle", 32'(count_valid), 32'd0);

    // Abort near cycle 400: no report, previous results held.
    repeat (398) @(posedge sys_clk);
    @(negedge sys_clk);
    enable = 1'b0;
    pulses = 0;
    repeat (1200) begin
      @(posedge sys_clk);
      #1;
      if (count_valid === 1'b1) pulses++;
    end
    check("abort_no_report", 32'(pulses), 32'd0);
    check_count("abort_held", last_exp);
    check("abort_held_freq_ok", 32'(freq_ok), 32'(last_exp.ok));
    check("abort_freq_err", 32'(freq_err), 32'd1);

    @(negedge sys_clk);
    enable = 1'b1;
    push_exp("w7_reenable", 499, 501, 1'b1, 1'b1);
    wait_report(lat);
    check("w7_latency", 32'(lat), 32'(WIN + 1));

    // Stop sdram_clk.
    sdram_run = 1'b0;
    push_exp("w8_stop_edge", 0, 2, 1'b0, 1'b1);
`ifdef CLK_LOSS_DET_EN
    seen = 1'b0;
    for (int i = 0; i < 24 && !seen; i++) begin
      @(posedge sys_clk);
      #1;
      seen = (clk_lost === 1'b1);
    end
    check("loss_rise", 32'(seen), 32'd1);
`else
    seen = 1'b0;
    repeat (30) begin
      @(posedge sys_clk);
      #1;
      if (clk_lost !== 1'b0) seen = 1'b1;
    end
    check("loss_tied_low", 32'(seen), 32'd0);
`endif
    wait_report(lat);
    push_exp("w9_stopped", 0, 0, 1'b0, 1'b1);
    wait_report(lat);
`ifdef CLK_LOSS_DET_EN
    check("loss_held", 32'(clk_lost), 32'd1);
`else
    check("loss_still_low", 32'(clk_lost), 32'd0);
`endif

    // Restart clock.
    sdram_run = 1'b1;
`ifdef CLK_LOSS_DET_EN
    seen = 1'b0;
    for (int i = 0; i < 5 && !seen; i++) begin
      @(posedge sys_clk);
      #1;
      seen = (clk_lost === 1'b0);
    end
    check("loss_fall", 32'(seen), 32'd1);
`endif

    // Asynchronous reset mid-window after a failing window.
    repeat (699) @(posedge sys_clk);
    #2 RESET = 1'b1;
    #1;
    check_all_zero("midreset");
    sb.delete();
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    RESET = 1'b0;
    push_exp("w11_post_reset", 499, 501, 1'b1, 1'b0);
    wait_report(lat);
    check("w11_latency", 32'(lat), 32'(WIN + 1));
    check("w11_clk_lost", 32'(clk_lost), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
